// File: rtl/display_list_pingpong.sv
`default_nettype none
// ============================================================================
// Module      : display_list_pingpong
// Description : Ping-pong bank arbiter for the display-list shared RAM. The
//               physics beta (host) builds the next frame in one bank while
//               the laser beta (client) scans the other. A commit/done
//               handshake, backed by a watchdog, decides when the banks swap.
//
// Ports       : clk, resetn          - clock, synchronous active-low reset
//               host_addr/host_we    - host word address and write request
//               host_commit          - strobe: host finished a frame
//               client_addr          - client word address
//               client_done          - strobe: client finished scanning
//               host_ram_addr/_we    - {bank, addr} and gated write to RAM
//               client_ram_addr      - {~bank, addr} to RAM client port
//               host_busy            - a commit is outstanding
//               swap_irq             - one-cycle pulse: new frame live
//               frame_count          - completed swaps (wraps)
//               replay_count         - done strobes with no new frame (wraps)
//               timeout_count        - forced swaps (saturates at 255)
//
// Revision    : 1.0 - initial release
// ============================================================================
module display_list_pingpong #(
    parameter int          ADDR_BITS = 10,
    parameter logic [23:0] TIMEOUT   = 24'd500000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic                 host_we,
    input  logic                 host_commit,
    input  logic [ADDR_BITS-1:0] client_addr,
    input  logic                 client_done,
    output logic [ADDR_BITS:0]   host_ram_addr,
    output logic                 host_ram_we,
    output logic [ADDR_BITS:0]   client_ram_addr,
    output logic                 host_busy,
    output logic                 swap_irq,
    output logic [15:0]          frame_count,
    output logic [15:0]          replay_count,
    output logic [7:0]           timeout_count
);

    localparam int                 c_WD_BITS = $clog2(TIMEOUT);
    localparam logic [c_WD_BITS-1:0] c_WD_LAST = c_WD_BITS'(TIMEOUT - 24'd1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SWAP    = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_host_bank;
    logic [c_WD_BITS-1:0]   r_watchdog;
    logic [15:0]            r_frame_count;
    logic [15:0]            r_replay_count;
    logic [7:0]             r_timeout_count;
    logic                   w_forced;
    logic                   w_replay;

    // Next-state logic. A client_done arriving together with the last
    // watchdog cycle counts as a normal swap, not a forced one.
    always_comb begin
        w_next_state = r_state;
        w_forced     = 1'b0;
        w_replay     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (host_commit && client_done) begin
                    w_next_state = ST_SWAP;
                end else if (host_commit) begin
                    w_next_state = ST_PENDING;
                end else if (client_done) begin
                    w_replay = 1'b1;
                end
            end
            ST_PENDING: begin
                if (client_done) begin
                    w_next_state = ST_SWAP;
                end else if (r_watchdog == c_WD_LAST) begin
                    w_next_state = ST_SWAP;
                    w_forced     = 1'b1;
                end
            end
            ST_SWAP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state         <= ST_IDLE;
            r_host_bank     <= 1'b0;
            r_watchdog      <= '0;
            r_frame_count   <= 16'd0;
            r_replay_count  <= 16'd0;
            r_timeout_count <= 8'd0;
        end else begin
            r_state <= w_next_state;

            // Held at zero outside PENDING, so it is clear on every entry.
            if (r_state == ST_PENDING) begin
                r_watchdog <= r_watchdog + c_WD_BITS'(1);
            end else begin
                r_watchdog <= '0;
            end

            if (r_state == ST_SWAP) begin
                r_host_bank   <= ~r_host_bank;
                r_frame_count <= r_frame_count + 16'd1;
            end

            if (w_replay) begin
                r_replay_count <= r_replay_count + 16'd1;
            end

            if (w_forced && (r_timeout_count != 8'hFF)) begin
                r_timeout_count <= r_timeout_count + 8'd1;
            end
        end
    end

    // Address muxing stays combinational so the beta memory path sees no
    // added latency; the two ports are always on opposite banks.
    assign host_busy       = (r_state != ST_IDLE);
    assign swap_irq        = (r_state == ST_SWAP);
    assign host_ram_addr   = {r_host_bank, host_addr};
    assign client_ram_addr = {~r_host_bank, client_addr};
    assign host_ram_we     = host_we & ~host_busy;
    assign frame_count     = r_frame_count;
    assign replay_count    = r_replay_count;
    assign timeout_count   = r_timeout_count;

endmodule
`default_nettype wire

// File: tb/tb_display_list_pingpong.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_list_pingpong
// Description : Self-checking bench for display_list_pingpong. Directed
//               scenarios followed by random traffic, compared every cycle
//               against a frame-handoff reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_list_pingpong;

    localparam int          c_AB = 6;
    localparam int          c_TO = 8;

    logic               clk = 1'b0;
    logic               resetn;
    logic [c_AB-1:0]    host_addr;
    logic               host_we;
    logic               host_commit;
    logic [c_AB-1:0]    client_addr;
    logic               client_done;
    logic [c_AB:0]      host_ram_addr;
    logic               host_ram_we;
    logic [c_AB:0]      client_ram_addr;
    logic               host_busy;
    logic               swap_irq;
    logic [15:0]        frame_count;
    logic [15:0]        replay_count;
    logic [7:0]         timeout_count;

    always #5 clk = ~clk;

    display_list_pingpong #(
        .ADDR_BITS (c_AB),
        .TIMEOUT   (24'(c_TO))
    ) u_dut (
        .clk             (clk),
        .resetn          (resetn),
        .host_addr       (host_addr),
        .host_we         (host_we),
        .host_commit     (host_commit),
        .client_addr     (client_addr),
        .client_done     (client_done),
        .host_ram_addr   (host_ram_addr),
        .host_ram_we     (host_ram_we),
        .client_ram_addr (client_ram_addr),
        .host_busy       (host_busy),
        .swap_irq        (swap_irq),
        .frame_count     (frame_count),
        .replay_count    (replay_count),
        .timeout_count   (timeout_count)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a frame is either absent, waiting for the client
    // (with its age in cycles), or being handed over this cycle.
    bit m_bank;
    bit m_waiting;
    bit m_handover;
    int m_age;
    int m_frames;
    int m_replays;
    int m_timeouts;

    task automatic model_reset();
        m_bank     = 1'b0;
        m_waiting  = 1'b0;
        m_handover = 1'b0;
        m_age      = 0;
        m_frames   = 0;
        m_replays  = 0;
        m_timeouts = 0;
    endtask

    task automatic model_edge(input bit rn, input bit c, input bit d);
        if (!rn) begin
            model_reset();
        end else if (m_handover) begin
            m_handover = 1'b0;
            m_bank     = !m_bank;
            m_frames   = (m_frames + 1) % 65536;
        end else if (m_waiting) begin
            m_age = m_age + 1;
            if (d) begin
                m_waiting  = 1'b0;
                m_handover = 1'b1;
            end else if (m_age >= c_TO) begin
                m_waiting  = 1'b0;
                m_handover = 1'b1;
                if (m_timeouts < 255) m_timeouts = m_timeouts + 1;
            end
        end else if (c && d) begin
            m_handover = 1'b1;
        end else if (c) begin
            m_waiting = 1'b1;
            m_age     = 0;
        end else if (d) begin
            m_replays = (m_replays + 1) % 65536;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check all outputs against the model,
    // then advance both across the rising edge.
    task automatic step(input bit rn, input bit c, input bit d, input bit we);
        logic         busy;
        logic [c_AB:0] exp_h;
        logic [c_AB:0] exp_c;
        resetn      = rn;
        host_commit = c;
        client_done = d;
        host_we     = we;
        host_addr   = c_AB'($urandom);
        client_addr = c_AB'($urandom);
        #1;
        busy  = m_waiting || m_handover;
        exp_h = {m_bank, host_addr};
        exp_c = {!m_bank, client_addr};
        chk("host_ram_addr",   32'(host_ram_addr),   32'(exp_h));
        chk("client_ram_addr", 32'(client_ram_addr), 32'(exp_c));
        chk("host_ram_we",     32'(host_ram_we),     32'(we && !busy));
        chk("host_busy",       32'(host_busy),       32'(busy));
        chk("swap_irq",        32'(swap_irq),        32'(m_handover));
        chk("frame_count",     32'(frame_count),     32'(m_frames));
        chk("replay_count",    32'(replay_count),    32'(m_replays));
        chk("timeout_count",   32'(timeout_count),   32'(m_timeouts));
        @(posedge clk);
        model_edge(rn, c, d);
        #1;
    endtask

    initial begin
        resetn      = 1'b0;
        host_commit = 1'b0;
        client_done = 1'b0;
        host_we     = 1'b0;
        host_addr   = '0;
        client_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;

        // Reset values, checked while reset is still held.
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Normal handoff with writes attempted during busy.
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);          // commit ignored in PENDING
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);          // ignored during SWAP
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);

        // Replays in IDLE.
        repeat (3) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Simultaneous commit and done from IDLE.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Watchdog forced swap.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (12) step(1'b1, 1'b0, 1'b0, 1'b1);

        // Done on the last watchdog cycle is a normal swap.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (c_TO - 1) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset while PENDING, then a done must count as a replay.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 59) != 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 6) == 0,
                 $urandom_range(0, 1) == 1);
        end

        // Drive timeout_count into saturation.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 260; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            repeat (c_TO + 2) step(1'b1, 1'b0, 1'b0, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
